// File: rtl/delta_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delta_pkg
// Description : Shared defaults and state encoding for the delta-window
//               trigger scaler.
// Revision    : 1.0 - initial release
// ============================================================================
package delta_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_SEQ_W = 16;

    // COUNT: window open, counters accumulate.
    // HOLD : delta_rst high, counters held at zero.
    typedef enum logic [0:0] {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage : delta_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment. Exposes the value including the
//               current cycle's increment so a snapshot can capture it
//               in the same cycle the counter is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count_nxt
);

    logic [WIDTH-1:0] r_count;

    // Stored value plus this cycle's increment, pinned at all-ones.
    always_comb begin
        count_nxt = r_count;
        if (inc && (r_count != {WIDTH{1'b1}})) begin
            count_nxt = r_count + 1'b1;
        end
    end

    // Counter register: clear wins, otherwise take the incremented value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else begin
            r_count <= count_nxt;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/delta_scaler.sv
`default_nettype none
// ============================================================================
// Module      : delta_scaler
// Description : Per-window trigger scaler. Counts live-gated trigger rising
//               edges per channel and live cycles between delta windows,
//               snapshots them into a one-deep readout buffer on each
//               delta_rst rising edge, and holds the counters cleared while
//               delta_rst stays high.
// Revision    : 1.0 - initial release
// ============================================================================
module delta_scaler
    import delta_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SEQ_W = DEF_SEQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 delta_rst,
    input  logic                 live,
    input  logic [NCH-1:0]       trig,
    input  logic                 snap_ready,
    input  logic                 overrun_clr,
    output logic                 snap_valid,
    output logic [NCH*CNT_W-1:0] snap_cnt,
    output logic [CNT_W-1:0]     snap_live,
    output logic [SEQ_W-1:0]     snap_seq,
    output logic                 overrun
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [NCH-1:0]       r_trig_d;
    logic                 r_drst_d;
    state_t               r_state;
    state_t               w_state_nxt;

    logic [NCH-1:0]       w_edge;
    logic                 w_drise;
    logic                 w_cnt_en;
    logic                 w_clr;
    logic                 w_buf_free;
    logic                 w_xfer;

    logic [NCH*CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0]     w_live_nxt;

    logic                 r_snap_valid;
    logic [NCH*CNT_W-1:0] r_snap_cnt;
    logic [CNT_W-1:0]     r_snap_live;
    logic [SEQ_W-1:0]     r_snap_seq;
    logic [SEQ_W-1:0]     r_seq;
    logic                 r_overrun;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // Delayed copies keep tracking in HOLD so an edge seen there is not
    // recounted once the window reopens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_d <= '0;
            r_drst_d <= 1'b0;
        end else begin
            r_trig_d <= trig;
            r_drst_d <= delta_rst;
        end
    end

    assign w_edge  = trig & ~r_trig_d;
    assign w_drise = delta_rst & ~r_drst_d;

    // ------------------------------------------------------------------
    // Window state machine
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter HOLD on the window edge, leave when delta_rst drops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COUNT:   if (w_drise)    w_state_nxt = HOLD;
            HOLD:    if (!delta_rst) w_state_nxt = COUNT;
            default: w_state_nxt = COUNT;
        endcase
    end

    // Counting is live in COUNT (including the drise cycle itself, whose
    // increment belongs to the closing window) and from the first cycle
    // delta_rst is seen low, even though the state register still says HOLD.
    assign w_cnt_en = (r_state == COUNT) || !delta_rst;

    // Clear on the window edge and for as long as the reset pulse lasts.
    assign w_clr = w_drise || ((r_state == HOLD) && delta_rst);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            sat_counter #(
                .WIDTH (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (w_cnt_en && live && w_edge[gi]),
                .clr       (w_clr),
                .count_nxt (w_cnt_nxt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_live_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_cnt_en && live),
        .clr       (w_clr),
        .count_nxt (w_live_nxt)
    );

    // ------------------------------------------------------------------
    // Snapshot buffer and handshake
    // ------------------------------------------------------------------
    assign w_xfer     = r_snap_valid && snap_ready;
    assign w_buf_free = !r_snap_valid || snap_ready;

    // One-deep buffer: load on a window edge when free, otherwise keep the
    // unread snapshot untouched and let the sequence gap expose the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_valid <= 1'b0;
            r_snap_cnt   <= '0;
            r_snap_live  <= '0;
            r_snap_seq   <= '0;
        end else if (w_drise && w_buf_free) begin
            r_snap_valid <= 1'b1;
            r_snap_cnt   <= w_cnt_nxt;
            r_snap_live  <= w_live_nxt;
            r_snap_seq   <= r_seq;
        end else if (w_xfer) begin
            r_snap_valid <= 1'b0;
        end
    end

    // Window sequence number, advanced for every window whether kept or lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else if (w_drise) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    // Sticky overrun flag; a new loss beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drise && !w_buf_free) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign snap_valid = r_snap_valid;
    assign snap_cnt   = r_snap_cnt;
    assign snap_live  = r_snap_live;
    assign snap_seq   = r_snap_seq;
    assign overrun    = r_overrun;

endmodule : delta_scaler
`default_nettype wire
